// File: rtl/bcd_to_bin_mul10.sv
// bcd_to_bin_mul10: sequential 4-digit packed-BCD to 16-bit binary converter.
// Horner evaluation acc = acc*10 + digit, most significant digit first. The
// multiply by ten is ten successive additions of acc into a product register,
// counted by cnt, so the datapath is a single 16-bit adder.
// Optional macro BCD_CHECK_EN: when defined, a start with any nibble above 9
// aborts with err=1 and Data_out=0. When undefined, nibbles convert with their
// plain binary value (0..15) and err is tied low.
module bcd_to_bin_mul10 (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [15:0] digits;
  logic [15:0] acc;
  logic [15:0] prod;
  logic [3:0]  cnt;
  logic [1:0]  didx;
  logic [3:0]  digit_cur;
  logic [15:0] sum;

  // Select one BCD nibble by digit index (3 = most significant).
  function automatic logic [3:0] nibble(input logic [15:0] word, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd3:    n = word[15:12];
      2'd2:    n = word[11:8];
      2'd1:    n = word[7:4];
      default: n = word[3:0];
    endcase
    return n;
  endfunction

  assign digit_cur = nibble(digits, didx);
  assign sum       = prod + {12'd0, digit_cur};

`ifdef BCD_CHECK_EN
  logic err_q;
  logic bad_q;

  // True when any of the four nibbles is not a decimal digit.
  function automatic logic has_bad_digit(input logic [15:0] word);
    return (word[15:12] > 4'd9) || (word[11:8] > 4'd9) ||
           (word[7:4]   > 4'd9) || (word[3:0]  > 4'd9);
  endfunction

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Conversion FSM with registered outputs; Data_out only moves on DONE entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      Data_out <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc      <= 16'd0;
      prod     <= 16'd0;
      cnt      <= 4'd0;
      didx     <= 2'd0;
`ifdef BCD_CHECK_EN
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            digits <= Data_in;
            acc    <= 16'd0;
            prod   <= 16'd0;
            cnt    <= 4'd0;
            didx   <= 2'd3;
            busy   <= 1'b1;
            state  <= MUL;
`ifdef BCD_CHECK_EN
            err_q  <= 1'b0;
            bad_q  <= has_bad_digit(Data_in);
`endif
          end
        end
        MUL: begin
`ifdef BCD_CHECK_EN
          // The validity flag is registered at capture, so an invalid word
          // leaves from the first MUL cycle without doing any arithmetic.
          if (bad_q) begin
            Data_out <= 16'd0;
            err_q    <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            prod <= prod + acc;
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd9) state <= ADD;
          end
`else
          prod <= prod + acc;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd9) state <= ADD;
`endif
        end
        ADD: begin
          acc <= sum;
          if (didx == 2'd0) begin
            // Final digit: publish the result so it is visible during DONE.
            Data_out <= sum;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            didx  <= didx - 2'd1;
            prod  <= 16'd0;
            cnt   <= 4'd0;
            state <= MUL;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_mul10.sv
// tb_bcd_to_bin_mul10: table-driven and randomized checks of bcd_to_bin_mul10
// against a decimal-arithmetic reference model.
module tb_bcd_to_bin_mul10;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] Data_in;
  logic [15:0] Data_out;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  bcd_to_bin_mul10 dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .Data_in  (Data_in),
    .Data_out (Data_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        e;
  } vec_t;

  vec_t vecs[8];

  // Reference: decimal value of the nibbles (each weighted by a power of ten).
  function automatic void model(input logic [15:0] din, output logic [15:0] dout, output logic e);
    int value;
    int d;
    value = 0;
    e = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = (din >> (4 * i)) & 15;
      if (d > 9) e = 1'b1;
      value = value * 10 + d;
    end
`ifdef BCD_CHECK_EN
    if (e) value = 0;
`else
    e = 1'b0;
`endif
    dout = 16'(value);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One conversion: start pulse, scrambled Data_in while busy, optional
  // second start at cycle 10, then latency/result/hold checks.
  task automatic conv(input logic [15:0] din, input logic [15:0] exp_dout,
                      input logic exp_err, input bit inject, input string name);
    int edges;
    int exp_lat;
    bit busy_ok;
    bit hold_ok;
    logic [15:0] hold;
    hold    = Data_out;
    exp_lat = exp_err ? 1 : 44;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    Data_in = din;
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 0;
    while (edges < 100) begin
      if (done) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (Data_out !== hold) hold_ok = 1'b0;
      if (inject && edges == 9) begin
        start   = 1'b1;
        Data_in = 16'h5678;
      end else begin
        start   = 1'b0;
        Data_in = 16'($urandom);
      end
      @(posedge clock); #1;
      edges++;
    end
    start = 1'b0;
    chk({name, " done_seen"}, {31'd0, done}, 32'd1);
    chk({name, " latency"}, edges, exp_lat);
    chk({name, " busy_during"}, {31'd0, busy_ok}, 32'd1);
    chk({name, " out_hold"}, {31'd0, hold_ok}, 32'd1);
    chk({name, " data_out"}, {16'd0, Data_out}, {16'd0, exp_dout});
    chk({name, " err"}, {31'd0, err}, {31'd0, exp_err});
    @(posedge clock); #1;
    chk({name, " done_pulse_end"}, {30'd0, done, busy}, 32'd0);
    chk({name, " out_after"}, {16'd0, Data_out}, {16'd0, exp_dout});
  endtask

  initial begin
    logic [15:0] m_out;
    logic        m_err;
    logic [15:0] rnd;
    bit          quiet;

    vecs[0] = '{16'h1234, 16'd1234, 1'b0};
    vecs[1] = '{16'h9999, 16'd9999, 1'b0};
    vecs[2] = '{16'h0000, 16'd0,    1'b0};
    vecs[3] = '{16'h0001, 16'd1,    1'b0};
    vecs[4] = '{16'h5678, 16'd5678, 1'b0};
    vecs[5] = '{16'h9000, 16'd9000, 1'b0};
`ifdef BCD_CHECK_EN
    vecs[6] = '{16'h12A4, 16'd0,     1'b1};
    vecs[7] = '{16'hFFFF, 16'd0,     1'b1};
`else
    vecs[6] = '{16'h12A4, 16'd1304,  1'b0};
    vecs[7] = '{16'hFFFF, 16'd16665, 1'b0};
`endif

    // Reset with start held high must leave everything idle.
    reset   = 1'b1;
    start   = 1'b1;
    Data_in = 16'h1234;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state", {16'd0, Data_out}, 32'd0);
    chk("reset_flags", {29'd0, busy, done, err}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock); #1;
    chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      conv(vecs[i].din, vecs[i].dout, vecs[i].e, 1'b0, $sformatf("vec%0d", i));
    end

    // Result retained across idle cycles with Data_in moving.
    quiet = 1'b1;
    m_out = Data_out;
    for (int i = 0; i < 6; i++) begin
      Data_in = 16'($urandom);
      @(posedge clock); #1;
      if (Data_out !== m_out || done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("idle_retain", {31'd0, quiet}, 32'd1);

    // Second start while busy is ignored; then a real 0x5678 conversion.
    conv(16'h1234, 16'h04D2, 1'b0, 1'b1, "busy_start");
    conv(16'h5678, 16'h162E, 1'b0, 1'b0, "after_busy");

    // Reset mid-conversion aborts with no done pulse.
    Data_in = 16'h1234;
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    start = 1'b0;
    chk("abort_out", {16'd0, Data_out}, 32'd0);
    chk("abort_flags", {29'd0, busy, done, err}, 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("abort_no_done", {31'd0, quiet}, 32'd1);
    conv(16'h0042, 16'h002A, 1'b0, 1'b0, "post_abort");

    // Randomized words against the reference model.
    for (int i = 0; i < 12; i++) begin
      rnd = 16'($urandom);
      if (i % 2 == 0) begin
        rnd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      model(rnd, m_out, m_err);
      conv(rnd, m_out, m_err, 1'b0, $sformatf("rand%0d_%04h", i, rnd));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_mul10.md
BCD_TO_BIN_MUL10 -- requirements
Module: bcd_to_bin_mul10

Interface
REQ-001 Parameter: none; widths fixed at 16-bit data, 4 BCD digits.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request conversion; sampled only in IDLE.
REQ-005 Data_in  input  16  packed BCD, digit 3 = [15:12] (most significant) .. digit 0 = [3:0].
REQ-006 Data_out  output  16  binary result; held stable until next accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse, high only in DONE state.
REQ-009 err  output  1  invalid-digit flag; valid with done (see Configuration).

Function
REQ-010 Algorithm SHALL be Horner form acc = acc*10 + digit, digit 3 first; multiply-by-10 SHALL be repeated addition (10 adds via counter), no multiplier or shift-add.
REQ-011 FSM states SHALL be IDLE, MUL, ADD, DONE; registered state, registered outputs.
REQ-012 IDLE: on start=1, capture Data_in into digit register, clear acc, product P, add counter cnt (4-bit), set digit index didx=3, go MUL; start=0 stays IDLE.
REQ-013 MUL: each cycle P <= P + acc, cnt <= cnt+1; cycle with cnt==9 performs the 10th add and goes ADD.
REQ-014 ADD: acc <= P + digit[didx]; if didx==0 go DONE, else didx <= didx-1, P <= 0, cnt <= 0, go MUL.
REQ-015 DONE: Data_out <= acc (visible this cycle), done=1 for exactly this cycle, then IDLE unconditionally.
REQ-016 Latency: start sampled at edge E0; 4 x (10 MUL + 1 ADD) = 44 cycles; done high in the 45th cycle after E0; next start accepted at the edge ending DONE+1 (IDLE).
REQ-017 start while busy SHALL be ignored; Data_in changes while busy SHALL not affect the result.
REQ-018 All arithmetic 16-bit unsigned; max result 9999 (0x270F), with checking disabled max 16665, no overflow possible.
REQ-019 Data_out SHALL retain last result across IDLE cycles and SHALL not change during conversion.

Reset
REQ-020 reset=1 at any posedge SHALL force IDLE, Data_out=0, done=0, err=0, busy=0, acc=P=cnt=0, overriding all other inputs.
REQ-021 Reset mid-conversion SHALL abort with no done pulse; start in the same cycle as reset SHALL be ignored.

Configuration
REQ-022 Macro BCD_CHECK_EN SHALL gate digit validation.
REQ-023 Defined: on accepted start, if any nibble > 9, FSM SHALL skip MUL/ADD and go IDLE->DONE with err=1, Data_out=0; done in 2nd cycle after E0; err cleared on next accepted start.
REQ-024 Undefined: no check; nibbles converted with their binary value 0..15; err tied to 0.

Verification
REQ-025 Data_in=0x1234, start pulse -> busy 44 cycles, done in cycle 45, Data_out=0x04D2, err=0.
REQ-026 Data_in=0x9999 -> Data_out=0x270F; Data_in=0x0000 -> Data_out=0x0000, same 45-cycle latency.
REQ-027 Data_in=0x12A4 -> with BCD_CHECK_EN: err=1, Data_out=0, done in cycle 2; without: Data_out=1304 (0x0518), done cycle 45.
REQ-028 Start 0x1234, second start with 0x5678 at cycle 10 -> ignored, result 0x04D2; then start 0x5678 -> 0x162E.
REQ-029 Start 0x1234, reset at cycle 20 -> IDLE next cycle, no done, Data_out=0; subsequent start 0x0042 -> 0x002A.
